// File: rtl/cnn_pkg.sv
// Shared CNN constants: data width, pooled map sizes, cfg_state encoding and
// the read-side FSM states of the pool frame buffer.
package cnn_pkg;
    localparam int DW     = 8;
    localparam int MAP_W0 = 12;
    localparam int MAP_W1 = 4;
    localparam int AW     = 8;

    localparam logic STATE_24X24 = 1'b0;
    localparam logic STATE_8X8   = 1'b1;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_SEND  = 2'd2
    } rd_state_t;
endpackage

// File: rtl/pool_buf_bank.sv
// One frame bank: simple dual-port RAM, one write port and one registered read port.
module pool_buf_bank #(
    parameter int DW = cnn_pkg::DW,
    parameter int AW = cnn_pkg::AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/pool_frame_buffer.sv
// Ping-pong buffer that captures pooled maps and replays them over valid/ready.
// Optional sticky drop flag `err` is built in when POOL_BUF_ERR_EN is defined.
module pool_frame_buffer #(
    parameter int DW     = cnn_pkg::DW,
    parameter int MAP_W0 = cnn_pkg::MAP_W0,
    parameter int MAP_W1 = cnn_pkg::MAP_W1,
    parameter int AW     = cnn_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_state,
    input  logic          ivalid,
    input  logic [DW-1:0] din,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_col_last,
    output logic          o_last,
    output logic          frame_done
`ifdef POOL_BUF_ERR_EN
    ,
    output logic          err
`endif
);
    import cnn_pkg::*;

    localparam logic [AW-1:0] COL_MAX0 = AW'(MAP_W0 - 1);
    localparam logic [AW-1:0] COL_MAX1 = AW'(MAP_W1 - 1);
    localparam logic [AW-1:0] LAST0    = AW'(MAP_W0 * MAP_W0 - 1);
    localparam logic [AW-1:0] LAST1    = AW'(MAP_W1 * MAP_W1 - 1);

    logic [1:0]    full_q, full_d;
    logic [1:0]    bank_cfg_q, bank_cfg_d;
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic          wr_cfg_q, wr_cfg_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, col_q, col_d;
    rd_state_t     state_q, state_d;
    logic          frame_done_q, frame_done_d;
    logic          o_valid_q, o_valid_d, o_col_last_q, o_col_last_d, o_last_q, o_last_d;
    logic [DW-1:0] o_data_q, o_data_d;

    logic          wr_cur_cfg, wr_ok, rd_cfg;
    logic [AW-1:0] wr_last, rd_col_max, rd_last, rd_addr;
    logic [1:0]    bank_we;
    logic [DW-1:0] bank_rdata [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            pool_buf_bank #(.DW(DW), .AW(AW)) u_bank (
                .clk   (clk),
                .we    (bank_we[gi]),
                .waddr (wr_cnt_q),
                .wdata (din),
                .raddr (rd_addr),
                .rdata (bank_rdata[gi])
            );
        end
    endgenerate

    always_comb begin
        full_d       = full_q;
        bank_cfg_d   = bank_cfg_q;
        wr_bank_d    = wr_bank_q;
        wr_cfg_d     = wr_cfg_q;
        wr_cnt_d     = wr_cnt_q;
        frame_done_d = 1'b0;
        bank_we      = 2'b00;

        // The map size is taken from cfg_state on the first beat of a frame only.
        wr_cur_cfg = (wr_cnt_q == '0) ? cfg_state : wr_cfg_q;
        wr_last    = (wr_cur_cfg == STATE_8X8) ? LAST1 : LAST0;
        wr_ok      = ivalid && !full_q[wr_bank_q];

        if (wr_ok) begin
            bank_we[wr_bank_q] = 1'b1;
            if (wr_cnt_q == '0) begin
                wr_cfg_d              = cfg_state;
                bank_cfg_d[wr_bank_q] = cfg_state;
            end
            if (wr_cnt_q == wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_cnt_d          = '0;
                frame_done_d      = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end

        rd_cfg       = bank_cfg_q[rd_bank_q];
        rd_col_max   = (rd_cfg == STATE_8X8) ? COL_MAX1 : COL_MAX0;
        rd_last      = (rd_cfg == STATE_8X8) ? LAST1 : LAST0;
        rd_addr      = '0;
        state_d      = state_q;
        rd_bank_d    = rd_bank_q;
        rd_cnt_d     = rd_cnt_q;
        col_d        = col_q;
        o_valid_d    = o_valid_q;
        o_data_d     = o_data_q;
        o_col_last_d = o_col_last_q;
        o_last_d     = o_last_q;

        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_cnt_d = '0;
                    col_d    = '0;
                    state_d  = RD_FETCH;
                end
            end
            RD_FETCH: begin
                o_data_d     = bank_rdata[rd_bank_q];
                o_valid_d    = 1'b1;
                o_col_last_d = (col_q == rd_col_max);
                o_last_d     = (rd_cnt_q == rd_last);
                state_d      = RD_SEND;
            end
            RD_SEND: begin
                // Prefetch the next address so FETCH sees its data one cycle later.
                rd_addr = rd_cnt_q + 1'b1;
                if (o_ready) begin
                    o_valid_d = 1'b0;
                    if (o_last_q) begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        state_d           = RD_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        col_d    = (col_q == rd_col_max) ? '0 : col_q + 1'b1;
                        state_d  = RD_FETCH;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q       <= '0;
            bank_cfg_q   <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_cfg_q     <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            col_q        <= '0;
            state_q      <= RD_IDLE;
            frame_done_q <= 1'b0;
            o_valid_q    <= 1'b0;
            o_data_q     <= '0;
            o_col_last_q <= 1'b0;
            o_last_q     <= 1'b0;
        end else begin
            full_q       <= full_d;
            bank_cfg_q   <= bank_cfg_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_cfg_q     <= wr_cfg_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            col_q        <= col_d;
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
            o_valid_q    <= o_valid_d;
            o_data_q     <= o_data_d;
            o_col_last_q <= o_col_last_d;
            o_last_q     <= o_last_d;
        end
    end

`ifdef POOL_BUF_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (ivalid && full_q[wr_bank_q]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign o_valid    = o_valid_q;
    assign o_data     = o_data_q;
    assign o_col_last = o_col_last_q;
    assign o_last     = o_last_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_pool_frame_buffer.sv
// Bench for pool_frame_buffer: frame-level scoreboard plus table-driven and hand-written scenarios.
module tb_pool_frame_buffer;
    import cnn_pkg::*;

    logic          clk = 1'b0;
    logic          rst, cfg_state, ivalid, o_ready;
    logic          o_valid, o_col_last, o_last, frame_done;
    logic [DW-1:0] din, o_data;
`ifdef POOL_BUF_ERR_EN
    logic          err;
`endif

    pool_frame_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_state  (cfg_state),
        .ivalid     (ivalid),
        .din        (din),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_col_last (o_col_last),
        .o_last     (o_last),
        .frame_done (frame_done)
`ifdef POOL_BUF_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ready_mode = 2;   // 0: always ready, 1: random, 2: never ready

    int delivered = 0, dut_fd = 0, cl_cnt = 0, last_cnt = 0, acc_beats = 0;

    // Reference model: complete frames waiting/being read, plus the frame being captured.
    logic [7:0] fq_data [$];
    int         fq_len [$];
    int         fq_w [$];
    logic [7:0] part [$];
    int         part_w = MAP_W0;
    int         rd_idx = 0;
    logic       exp_fd = 1'b0;
    logic       exp_err = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        o_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       o_ready = 1'b1;
                1:       o_ready = 1'($urandom_range(0, 1));
                default: o_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_o_valid", 32'(o_valid), 32'd0);
            fq_data.delete();
            fq_len.delete();
            fq_w.delete();
            part.delete();
            rd_idx     = 0;
            exp_fd     = 1'b0;
            exp_err    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("frame_done", 32'(frame_done), 32'(exp_fd));
`ifdef POOL_BUF_ERR_EN
            chk("err", 32'(err), 32'(exp_err));
`endif
            if (frame_done) dut_fd++;
            if (prev_stall) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_data", 32'(o_data), 32'(prev_data));
            end
            if (o_valid) begin
                if (fq_len.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_valid actual=1 required=0");
                end else begin
                    chk("o_data", 32'(o_data), 32'(fq_data[rd_idx]));
                    chk("o_col_last", 32'(o_col_last), 32'((rd_idx % fq_w[0]) == fq_w[0] - 1));
                    chk("o_last", 32'(o_last), 32'(rd_idx == fq_len[0] - 1));
                end
            end
            prev_stall = o_valid && (o_ready === 1'b0);
            prev_data  = o_data;

            // Effects of the coming clock edge, decided on pre-edge occupancy.
            exp_fd = 1'b0;
            if (ivalid) begin
                if (fq_len.size() < 2) begin
                    if (part.size() == 0) part_w = (cfg_state == STATE_8X8) ? MAP_W1 : MAP_W0;
                    part.push_back(din);
                    if (part.size() == part_w * part_w) begin
                        foreach (part[k]) fq_data.push_back(part[k]);
                        fq_len.push_back(part_w * part_w);
                        fq_w.push_back(part_w);
                        acc_beats += part_w * part_w;
                        part.delete();
                        exp_fd = 1'b1;
                    end
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (o_valid && o_ready) begin
                delivered++;
                if (o_col_last) cl_cnt++;
                if (o_last) last_cnt++;
                if (fq_len.size() > 0) begin
                    rd_idx++;
                    if (rd_idx == fq_len[0]) begin
                        for (int k = 0; k < fq_len[0]; k++) void'(fq_data.pop_front());
                        void'(fq_len.pop_front());
                        void'(fq_w.pop_front());
                        rd_idx = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // gap < 0 picks a random idle gap of 0..6 cycles (mean 3, i.e. ~1 beat per 4 cycles).
    task automatic send_beats(input int n, input logic cfg, input int base, input int gap, input bit rnd);
        for (int i = 0; i < n; i++) begin
            cfg_state = cfg;
            ivalid    = 1'b1;
            din       = rnd ? 8'($urandom) : 8'(base + i);
            tick();
            ivalid = 1'b0;
            din    = '0;
            repeat ((gap < 0) ? $urandom_range(0, 6) : gap) tick();
        end
    endtask

    task automatic wait_deliv(input string name, input int target);
        for (int n = 0; n < 6000 && delivered < target; n++) tick();
        chk(name, 32'(delivered), 32'(target));
    endtask

    typedef struct {
        logic cfg;
        int   nbeats;
        int   base;
        int   rmode;
        int   gap;
        bit   rnd;
        int   exp_deliv;
        int   exp_fd;
        int   exp_cl;
        int   exp_last;
    } vec_t;

    initial begin
        vec_t vecs [5];
        int   d0, f0, c0, l0, a0;

        vecs[0] = '{1'b0, 144, 0,   0, 3, 1'b0, 144, 1, 12, 1};
        vecs[1] = '{1'b1, 16,  100, 0, 3, 1'b0, 16,  1, 4,  1};
        vecs[2] = '{1'b0, 144, 0,   1, 3, 1'b0, 144, 1, 12, 1};
        vecs[3] = '{1'b1, 16,  0,   1, 0, 1'b1, 16,  1, 4,  1};
        vecs[4] = '{1'b1, 32,  0,   0, 1, 1'b1, 32,  2, 8,  2};

        rst = 1'b1;
        ivalid = 1'b0;
        din = '0;
        cfg_state = 1'b0;
        #25;
        chk("reset_o_valid", 32'(o_valid), 32'd0);
        chk("reset_o_data", 32'(o_data), 32'd0);
        chk("reset_o_col_last", 32'(o_col_last), 32'd0);
        chk("reset_o_last", 32'(o_last), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            ready_mode = vecs[v].rmode;
            d0 = delivered; f0 = dut_fd; c0 = cl_cnt; l0 = last_cnt;
            send_beats(vecs[v].nbeats, vecs[v].cfg, vecs[v].base, vecs[v].gap, vecs[v].rnd);
            wait_deliv($sformatf("vec%0d_delivered", v), d0 + vecs[v].exp_deliv);
            repeat (4) tick();
            chk($sformatf("vec%0d_frame_done", v), 32'(dut_fd - f0), 32'(vecs[v].exp_fd));
            chk($sformatf("vec%0d_col_last", v), 32'(cl_cnt - c0), 32'(vecs[v].exp_cl));
            chk($sformatf("vec%0d_last", v), 32'(last_cnt - l0), 32'(vecs[v].exp_last));
            chk($sformatf("vec%0d_idle", v), 32'(o_valid), 32'd0);
        end

        // Both banks full with the reader stalled: a third frame is dropped.
        ready_mode = 2;
        d0 = delivered; f0 = dut_fd;
        send_beats(16, 1'b1, 200, 3, 1'b0);
        send_beats(16, 1'b1, 216, 3, 1'b0);
        repeat (3) tick();
        chk("t4_two_frames", 32'(dut_fd - f0), 32'd2);
        chk("t4_hold_valid", 32'(o_valid), 32'd1);
        chk("t4_hold_data", 32'(o_data), 32'd200);
        send_beats(16, 1'b1, 50, 1, 1'b0);
        repeat (3) tick();
        chk("t4_no_third_frame", 32'(dut_fd - f0), 32'd2);
`ifdef POOL_BUF_ERR_EN
        chk("t4_err", 32'(err), 32'd1);
`endif
        ready_mode = 0;
        wait_deliv("t4_delivered", d0 + 32);
        repeat (4) tick();
        chk("t4_idle", 32'(o_valid), 32'd0);

        // Asynchronous reset while beat 50 is stalled in SEND.
        d0 = delivered;
        send_beats(144, 1'b0, 0, 3, 1'b0);
        wait_deliv("t5_reach_50", d0 + 50);
        ready_mode = 2;
        for (int n = 0; n < 20 && !o_valid; n++) tick();
        tick();
        chk("t5_beat50_data", 32'(o_data), 32'd50);
        chk("t5_beat50_valid", 32'(o_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_async_o_valid", 32'(o_valid), 32'd0);
        chk("t5_async_o_data", 32'(o_data), 32'd0);
        tick();
        rst = 1'b0;
        ready_mode = 0;
        d0 = delivered; f0 = dut_fd;
        send_beats(16, 1'b1, 30, 3, 1'b0);
        wait_deliv("t5_fresh_frame", d0 + 16);
        chk("t5_fresh_fd", 32'(dut_fd - f0), 32'd1);

        // cfg_state flips mid-frame: the frame stays 144 beats, the next is 16.
        d0 = delivered; f0 = dut_fd; c0 = cl_cnt; l0 = last_cnt;
        send_beats(11, 1'b0, 0, 3, 1'b0);
        send_beats(132, 1'b1, 11, 3, 1'b0);
        repeat (2) tick();
        chk("t6_not_done_143", 32'(dut_fd - f0), 32'd0);
        send_beats(1, 1'b1, 143, 3, 1'b0);
        chk("t6_done_144", 32'(dut_fd - f0), 32'd1);
        send_beats(16, 1'b1, 60, 3, 1'b0);
        wait_deliv("t6_delivered", d0 + 160);
        repeat (4) tick();
        chk("t6_frame_done", 32'(dut_fd - f0), 32'd2);
        chk("t6_col_last", 32'(cl_cnt - c0), 32'd16);
        chk("t6_last", 32'(last_cnt - l0), 32'd2);

        // Random frames, random data, random gaps and random backpressure.
        ready_mode = 1;
        d0 = delivered; a0 = acc_beats;
        for (int f = 0; f < 6; f++) begin
            logic c;
            c = 1'($urandom_range(0, 1));
            send_beats((c == STATE_8X8) ? MAP_W1 * MAP_W1 : MAP_W0 * MAP_W0, c, 0, -1, 1'b1);
        end
        wait_deliv("rand_delivered", d0 + (acc_beats - a0));
        repeat (6) tick();
        chk("rand_idle", 32'(o_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
